// File: rtl/poly_eval_driver.sv
// Drives the quadratic evaluator's press/release operand entry, samples its result
// and compares it against an internally computed truncating reference.
module poly_eval_driver #(
    parameter int WIDTH       = 8,
    parameter int HOLD        = 2,
    parameter int GAP         = 2,
    parameter int RESULT_WAIT = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] coef_a,
    input  logic [WIDTH-1:0] coef_b,
    input  logic [WIDTH-1:0] coef_c,
    input  logic [WIDTH-1:0] x_in,
    output logic [WIDTH-1:0] data_out,
    output logic             go,
    input  logic [WIDTH-1:0] result_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] expected,
    output logic             match
);

    localparam int MAX_DUR_HG = (HOLD > GAP) ? HOLD : GAP;
    localparam int MAX_DUR    = (MAX_DUR_HG > RESULT_WAIT) ? MAX_DUR_HG : RESULT_WAIT;
    localparam int CNT_W      = $clog2(MAX_DUR + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RESULT_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PRESS,
        S_RELEASE,
        S_WAIT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [1:0]       idx;
    logic [1:0]       idx_next;
    logic [WIDTH-1:0] dout_next;
    logic             accept;
    logic             capture;
    logic [WIDTH-1:0] ops [4];
    logic [WIDTH-1:0] ref_value;

    // Truncating multiply-accumulate, matching the evaluator's W-bit datapath.
    function automatic logic [WIDTH-1:0] mul_add(
        input logic [WIDTH-1:0] m,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] b
    );
        logic [2*WIDTH-1:0] prod;
        prod = {{WIDTH{1'b0}}, m} * {{WIDTH{1'b0}}, x};
        return prod[WIDTH-1:0] + b;
    endfunction

    assign ref_value = mul_add(mul_add(coef_a, x_in, coef_b), x_in, coef_c);

    assign go   = (state == S_PRESS);
    assign busy = (state != S_IDLE);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        dout_next  = data_out;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    idx_next   = 2'd0;
                    dout_next  = coef_a;
                    cnt_next   = '0;
                    state_next = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_next   = HOLD_LAST;
                state_next = S_PRESS;
            end
            S_PRESS: begin
                if (cnt == '0) begin
                    if (idx == 2'd3) begin
                        cnt_next   = WAIT_LAST;
                        state_next = S_WAIT;
                    end else begin
                        cnt_next   = GAP_LAST;
                        state_next = S_RELEASE;
                    end
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            S_RELEASE: begin
                if (cnt == '0) begin
                    idx_next   = idx + 2'd1;
                    dout_next  = ops[idx + 2'd1];
                    cnt_next   = '0;
                    state_next = S_SETUP;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    capture    = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx      <= 2'd0;
            data_out <= '0;
            done     <= 1'b0;
            result   <= '0;
            expected <= '0;
            match    <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            idx      <= idx_next;
            data_out <= dout_next;
            done     <= capture;
            if (accept) begin
                expected <= ref_value;
            end
            if (capture) begin
                result <= result_in;
                match  <= (result_in == expected);
            end
        end
    end

    // Operand store is pure data; it is always rewritten before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            ops[0] <= coef_a;
            ops[1] <= coef_b;
            ops[2] <= coef_c;
            ops[3] <= x_in;
        end
    end

endmodule

// File: tb/tb_poly_eval_driver.sv
// Directed bench for poly_eval_driver with a small behavioural evaluator attached
// to data_out/go/result_in.
module tb_poly_eval_driver;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [7:0] coef_a = 8'd0;
    logic [7:0] coef_b = 8'd0;
    logic [7:0] coef_c = 8'd0;
    logic [7:0] x_in = 8'd0;
    logic [7:0] data_out;
    logic       go;
    logic [7:0] result_in;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic [7:0] expected;
    logic       match;

    int total = 0;
    int bad = 0;

    poly_eval_driver #(
        .WIDTH(8), .HOLD(2), .GAP(2), .RESULT_WAIT(6)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .coef_a(coef_a), .coef_b(coef_b), .coef_c(coef_c), .x_in(x_in),
        .data_out(data_out), .go(go), .result_in(result_in),
        .busy(busy), .done(done), .result(result),
        .expected(expected), .match(match)
    );

    always #5 clk = ~clk;

    // Evaluator model: latches an operand on each go rise, computes after the fourth release.
    logic [7:0] ev_op [4];
    logic [2:0] ev_k;
    logic       ev_go_d;
    logic [7:0] ev_result;
    logic       tie_aa = 1'b0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ev_k      <= 3'd0;
            ev_go_d   <= 1'b0;
            ev_result <= 8'd0;
        end else begin
            ev_go_d <= go;
            if (go && !ev_go_d && ev_k < 3'd4) begin
                ev_op[ev_k[1:0]] <= data_out;
                ev_k             <= ev_k + 3'd1;
            end else if (!go && ev_go_d && ev_k == 3'd4) begin
                ev_result <= (ev_op[0] * ev_op[3] + ev_op[1]) * ev_op[3] + ev_op[2];
                ev_k      <= 3'd0;
            end
        end
    end

    assign result_in = tie_aa ? 8'hAA : ev_result;

    logic       go_log   [0:63];
    logic [7:0] dout_log [0:63];
    logic       busy_log [0:63];
    int         done_at;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one start in the current cycle and logs outputs per cycle (n = cycles after start).
    task automatic run_seq(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic [7:0] x, input int restart_at, input int reset_at);
        coef_a = a; coef_b = b; coef_c = c; x_in = x;
        start = 1'b1;
        go_log[0] = go;
        done_at = 0;
        tick();
        start = 1'b0;
        for (int n = 1; n < 64; n++) begin
            if (reset_at > 0 && n == reset_at + 1) begin
                resetn = 1'b1;
                break;
            end
            go_log[n]   = go;
            dout_log[n] = data_out;
            busy_log[n] = busy;
            if (done) begin
                done_at = n;
                break;
            end
            if (n == restart_at) begin
                start = 1'b1;
                coef_a = 8'd9; coef_b = 8'd9; coef_c = 8'd9; x_in = 8'd9;
            end else begin
                start = 1'b0;
            end
            if (n == reset_at) resetn = 1'b0;
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        total++;
        if ({go, busy, done, match} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctrl: go/busy/done/match=%b want 0000", {go, busy, done, match});
        end
        total++;
        if (data_out !== 8'h00) begin
            bad++; $display("FAIL reset_data_out: got %h want 00", data_out);
        end
        total++;
        if ({result, expected} !== 16'h0000) begin
            bad++; $display("FAIL reset_result_expected: got %h/%h want 00/00", result, expected);
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        run_seq(8'd2, 8'd3, 8'd4, 8'd5, 0, 0);
        total++;
        if (done_at !== 25) begin bad++; $display("FAIL basic_latency: got %0d want 25", done_at); end
        total++;
        if (expected !== 8'h45) begin bad++; $display("FAIL basic_expected: got %h want 45", expected); end
        total++;
        if (result !== 8'h45) begin bad++; $display("FAIL basic_result: got %h want 45", result); end
        total++;
        if (match !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL basic_match_busy: match=%b busy=%b want 1 0", match, busy);
        end
        tick();
        total++;
        if (done !== 1'b0 || result !== 8'h45) begin
            bad++; $display("FAIL basic_done_pulse: done=%b result=%h want 0 45", done, result);
        end
    endtask

    task automatic test_overflow();
        run_seq(8'd16, 8'd1, 8'd255, 8'd16, 0, 0);
        total++;
        if (expected !== 8'h0F) begin bad++; $display("FAIL ovf_expected: got %h want 0f", expected); end
        total++;
        if (result !== 8'h0F || match !== 1'b1) begin
            bad++; $display("FAIL ovf_result: got %h match=%b want 0f 1", result, match);
        end
    endtask

    task automatic test_go_waveform();
        logic [7:0] ops [4];
        int rises;
        int m;
        int k;
        logic exp_go;
        ops[0] = 8'h11; ops[1] = 8'h22; ops[2] = 8'h33; ops[3] = 8'h44;
        run_seq(ops[0], ops[1], ops[2], ops[3], 0, 0);
        total++;
        if (done_at !== 25) begin bad++; $display("FAIL wave_latency: got %0d want 25", done_at); end
        rises = 0;
        for (int n = 1; n <= 25; n++) begin
            m = (n - 1) % 5;
            exp_go = (n <= 20) && (m == 1 || m == 2);
            total++;
            if (go_log[n] !== exp_go) begin
                bad++; $display("FAIL wave_go_c%0d: got %b want %b", n, go_log[n], exp_go);
            end
            k = (n - 1) / 5;
            if (k > 3) k = 3;
            total++;
            if (dout_log[n] !== ops[k]) begin
                bad++; $display("FAIL wave_data_c%0d: got %h want %h", n, dout_log[n], ops[k]);
            end
            total++;
            if (busy_log[n] !== (n < 25)) begin
                bad++; $display("FAIL wave_busy_c%0d: got %b want %b", n, busy_log[n], (n < 25));
            end
            if (go_log[n] && !go_log[n-1]) rises++;
        end
        total++;
        if (rises !== 4) begin bad++; $display("FAIL wave_pulses: got %0d want 4", rises); end
    endtask

    task automatic test_mismatch();
        tie_aa = 1'b1;
        run_seq(8'd1, 8'd1, 8'd1, 8'd1, 0, 0);
        total++;
        if (expected !== 8'h03) begin bad++; $display("FAIL mm_expected: got %h want 03", expected); end
        total++;
        if (result !== 8'hAA) begin bad++; $display("FAIL mm_result: got %h want aa", result); end
        total++;
        if (match !== 1'b0) begin bad++; $display("FAIL mm_match: got %b want 0", match); end
        tie_aa = 1'b0;
    endtask

    task automatic test_restart_ignored();
        int rises;
        int extra_done;
        run_seq(8'd2, 8'd3, 8'd4, 8'd5, 7, 0);
        total++;
        if (done_at !== 25) begin bad++; $display("FAIL rst_ign_latency: got %0d want 25", done_at); end
        total++;
        if (dout_log[11] !== 8'd4 || dout_log[16] !== 8'd5) begin
            bad++; $display("FAIL rst_ign_operands: got %h %h want 04 05", dout_log[11], dout_log[16]);
        end
        total++;
        if (result !== 8'h45 || expected !== 8'h45 || match !== 1'b1) begin
            bad++; $display("FAIL rst_ign_result: got %h/%h match=%b want 45/45 1", result, expected, match);
        end
        rises = 0;
        for (int n = 1; n <= 25; n++) if (go_log[n] && !go_log[n-1]) rises++;
        extra_done = 0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (done) extra_done++;
            if (go) rises = rises + 100;
        end
        total++;
        if (rises !== 4 || extra_done !== 0) begin
            bad++; $display("FAIL rst_ign_single: pulses=%0d extra_done=%0d want 4 0", rises, extra_done);
        end
    endtask

    task automatic test_back_to_back();
        run_seq(8'd1, 8'd1, 8'd1, 8'd1, 0, 0);
        total++;
        if (done_at !== 25 || result !== 8'h03) begin
            bad++; $display("FAIL b2b_first: done_at=%0d result=%h want 25 03", done_at, result);
        end
        run_seq(8'd2, 8'd3, 8'd4, 8'd5, 0, 0);
        total++;
        if (done_at !== 25 || result !== 8'h45 || match !== 1'b1) begin
            bad++; $display("FAIL b2b_second: done_at=%0d result=%h match=%b want 25 45 1", done_at, result, match);
        end
    endtask

    task automatic test_reset_abort();
        int go_seen;
        run_seq(8'd7, 8'd8, 8'd9, 8'd10, 0, 14);
        total++;
        if ({go, busy, done, match} !== 4'b0000) begin
            bad++; $display("FAIL abort_ctrl: go/busy/done/match=%b want 0000", {go, busy, done, match});
        end
        total++;
        if ({data_out, result, expected} !== 24'h000000) begin
            bad++; $display("FAIL abort_data: got %h/%h/%h want 00/00/00", data_out, result, expected);
        end
        go_seen = 0;
        for (int n = 0; n < 10; n++) begin
            if (go || busy) go_seen++;
            tick();
        end
        total++;
        if (go_seen !== 0) begin bad++; $display("FAIL abort_quiet: got %0d active cycles want 0", go_seen); end
        run_seq(8'd2, 8'd3, 8'd4, 8'd5, 0, 0);
        total++;
        if (done_at !== 25 || result !== 8'h45 || match !== 1'b1) begin
            bad++; $display("FAIL abort_rerun: done_at=%0d result=%h match=%b want 25 45 1", done_at, result, match);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_go_waveform();
        test_mismatch();
        test_restart_ignored();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
